lcd_reset_responder: RTL and testbench
======================================

LCD_RESET_RESPONDER -- requirements
Module: lcd_reset_responder

Interface
REQ-001 SHALL have parameter MIN_LOW, default 4: minimum sampled-low cycles on panel reset line for a valid reset.
REQ-002 SHALL have parameter RECOVERY, default 2: cycles after valid reset release before bytes are accepted.
REQ-003 SHALL have parameter N_CFG, default 8: config bytes expected after each valid reset.
REQ-004 SHALL have parameter FRAME_BYTES, default 1024: pixel bytes per frame; address width $clog2(FRAME_BYTES).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low block reset.
REQ-007 lcd_rst  input  1  panel reset line from host, asynchronous to clk, active-low.
REQ-008 byte_valid  input  1  host byte strobe.
REQ-009 byte_in  input  8  host byte.
REQ-010 byte_ready  output  1  byte accepted when byte_valid && byte_ready.
REQ-011 cfg_we / cfg_addr / cfg_data  output  1 / 3 / 8  config register write.
REQ-012 px_we / px_addr / px_data  output  1 / addr width / 8  pixel memory write.
REQ-013 panel_ready  output  1  high in STREAM.
REQ-014 frame_done  output  1  one-cycle pulse on last byte of frame.

Function
REQ-015 lcd_rst SHALL pass a 2-flop synchronizer; FSM sees it 2 cycles late.
REQ-016 States SHALL be IDLE, LOW, RECOVER, CONFIG, STREAM.
REQ-017 IDLE: synced line low -> LOW with low counter cleared; no bytes accepted.
REQ-018 LOW: counter increments per cycle, saturating at MIN_LOW; on synced line high: count >= MIN_LOW -> RECOVER, else -> IDLE (glitch).
REQ-019 RECOVER: count RECOVERY cycles then -> CONFIG with byte counter 0.
REQ-020 CONFIG: each accepted byte SHALL pulse cfg_we next cycle with cfg_addr = byte index, cfg_data = byte; after byte N_CFG-1 -> STREAM with px_addr base 0.
REQ-021 STREAM: each accepted byte SHALL pulse px_we next cycle; address increments, wraps FRAME_BYTES-1 -> 0; frame_done pulses with the write of address FRAME_BYTES-1.
REQ-022 byte_ready SHALL be high exactly in CONFIG and STREAM, and low in the cycle the synced line is low.
REQ-023 Synced line low in RECOVER, CONFIG or STREAM SHALL go to LOW, clear all counters, drop panel_ready; byte presented that cycle is not accepted.
REQ-024 Pending cfg_we/px_we registered the cycle before a reset-line drop SHALL still complete.
REQ-025 Write strobes SHALL be single-cycle, never both high.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, synchronizer flops to 1, all counters 0, all outputs 0.
REQ-027 After rst_n release, a panel reset sequence SHALL be required before any byte is accepted.

Configuration
REQ-028 Macro LCD_RST_GLITCH_CNT_EN defined: extra output glitch_cnt (8 bits) counts LOW->IDLE rejections, saturates at 255, cleared only by rst_n.
REQ-029 Macro undefined: no glitch_cnt port or logic; behaviour otherwise identical.

Structure
REQ-030 Shared package lcd_pkg SHALL hold the state enum, default MIN_LOW/RECOVERY/N_CFG/FRAME_BYTES constants and config address width.
REQ-031 Synchronizer SHALL be sub-module lcd_rst_sync (2 flops, async reset to 1).

Verification
REQ-032 Host holds lcd_rst low 4 cycles, releases -> panel in CONFIG 2 sync + 2 recovery cycles after release, byte_ready=1.
REQ-033 lcd_rst low 2 cycles -> return to IDLE, byte_ready stays 0; with macro glitch_cnt=1.
REQ-034 Valid reset, 8 bytes 0x10..0x17 back-to-back -> cfg_we 8 pulses, cfg_addr 0..7 matching data, panel_ready=1 after last.
REQ-035 In STREAM send 1025 bytes -> px_addr 0..1023 then 0, frame_done once at address 1023.
REQ-036 lcd_rst low mid-STREAM at px_addr 37 -> panel_ready=0, byte_ready=0, next valid reset restarts at cfg_addr 0.
REQ-037 rst_n asserted mid-CONFIG -> all outputs 0 same cycle, IDLE after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and default constants for the LCD panel reset responder.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_RECOVER,
    ST_CONFIG,
    ST_STREAM
  } lcd_state_t;

  localparam int DEF_MIN_LOW     = 4;
  localparam int DEF_RECOVERY    = 2;
  localparam int DEF_N_CFG       = 8;
  localparam int DEF_FRAME_BYTES = 1024;
  localparam int CFG_AW          = 3;

endpackage

// File: rtl/lcd_rst_sync.sv
// Two-flop synchronizer for the host panel reset line; idles high (released).
module lcd_rst_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      meta_p0 <= async_in;
      sync_p1 <= meta_p0;
    end
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/lcd_reset_responder.sv
// Panel-side reset responder: qualifies host reset pulses, then routes config and pixel bytes.
// Optional LCD_RST_GLITCH_CNT_EN adds an 8-bit saturating count of rejected short reset pulses.
module lcd_reset_responder
  import lcd_pkg::*;
#(
  parameter int MIN_LOW     = DEF_MIN_LOW,
  parameter int RECOVERY    = DEF_RECOVERY,
  parameter int N_CFG       = DEF_N_CFG,
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  localparam int AW         = $clog2(FRAME_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_ready,
  output logic              cfg_we,
  output logic [CFG_AW-1:0] cfg_addr,
  output logic [7:0]        cfg_data,
  output logic              px_we,
  output logic [AW-1:0]     px_addr,
  output logic [7:0]        px_data,
  output logic              panel_ready,
`ifdef LCD_RST_GLITCH_CNT_EN
  output logic [7:0]        glitch_cnt,
`endif
  output logic              frame_done
);

  localparam int LW = $clog2(MIN_LOW + 1);
  localparam int RW = $clog2(RECOVERY + 1);

  lcd_state_t        state, state_d;
  logic [LW-1:0]     low_cnt, low_cnt_d;
  logic [RW-1:0]     rec_cnt, rec_cnt_d;
  logic [CFG_AW-1:0] cfg_cnt, cfg_cnt_d;
  logic [AW-1:0]     px_ptr, px_ptr_d;
  logic              line;
  logic              accept;
`ifdef LCD_RST_GLITCH_CNT_EN
  logic              glitch_d;
  logic [7:0]        glitch_q;
`endif

  lcd_rst_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (lcd_rst),
    .sync_out (line)
  );

  assign byte_ready  = line && (state == ST_CONFIG || state == ST_STREAM);
  assign panel_ready = (state == ST_STREAM);
  assign accept      = byte_valid && byte_ready;

  always_comb begin
    state_d   = state;
    low_cnt_d = low_cnt;
    rec_cnt_d = rec_cnt;
    cfg_cnt_d = cfg_cnt;
    px_ptr_d  = px_ptr;
`ifdef LCD_RST_GLITCH_CNT_EN
    glitch_d  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // The entry sample itself is the first counted low cycle.
        if (!line) begin
          state_d   = ST_LOW;
          low_cnt_d = LW'(1);
        end
      end
      ST_LOW: begin
        if (!line) begin
          if (low_cnt != LW'(MIN_LOW)) low_cnt_d = low_cnt + LW'(1);
        end else if (low_cnt >= LW'(MIN_LOW)) begin
          state_d   = ST_RECOVER;
          rec_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
`ifdef LCD_RST_GLITCH_CNT_EN
          glitch_d = 1'b1;
`endif
        end
      end
      ST_RECOVER: begin
        if (rec_cnt == RW'(RECOVERY - 1)) begin
          state_d   = ST_CONFIG;
          cfg_cnt_d = '0;
        end else begin
          rec_cnt_d = rec_cnt + RW'(1);
        end
      end
      ST_CONFIG: begin
        if (accept) begin
          if (cfg_cnt == CFG_AW'(N_CFG - 1)) begin
            state_d  = ST_STREAM;
            px_ptr_d = '0;
          end else begin
            cfg_cnt_d = cfg_cnt + CFG_AW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (accept) px_ptr_d = (px_ptr == AW'(FRAME_BYTES - 1)) ? '0 : px_ptr + AW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // A new reset pulse aborts any session in progress.
    if (!line && (state == ST_RECOVER || state == ST_CONFIG || state == ST_STREAM)) begin
      state_d   = ST_LOW;
      low_cnt_d = LW'(1);
      rec_cnt_d = '0;
      cfg_cnt_d = '0;
      px_ptr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      low_cnt <= '0;
      rec_cnt <= '0;
      cfg_cnt <= '0;
      px_ptr  <= '0;
    end else begin
      state   <= state_d;
      low_cnt <= low_cnt_d;
      rec_cnt <= rec_cnt_d;
      cfg_cnt <= cfg_cnt_d;
      px_ptr  <= px_ptr_d;
    end
  end

  // Write stage: accepted byte lands on the config or pixel port one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      px_we      <= 1'b0;
      px_addr    <= '0;
      px_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      cfg_we     <= accept && (state == ST_CONFIG);
      px_we      <= accept && (state == ST_STREAM);
      frame_done <= accept && (state == ST_STREAM) && (px_ptr == AW'(FRAME_BYTES - 1));
      if (accept && state == ST_CONFIG) begin
        cfg_addr <= cfg_cnt;
        cfg_data <= byte_in;
      end
      if (accept && state == ST_STREAM) begin
        px_addr <= px_ptr;
        px_data <= byte_in;
      end
    end
  end

`ifdef LCD_RST_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (glitch_d && glitch_q != 8'hFF) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_lcd_reset_responder.sv
// Directed bench for lcd_reset_responder: vector table for reset+config, hand sequences for stream and aborts.
module tb_lcd_reset_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_ready, cfg_we, px_we, panel_ready, frame_done;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data, px_data;
  logic [9:0] px_addr;
`ifdef LCD_RST_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int failures = 0;

  lcd_reset_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lcd_rst     (lcd_rst),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .byte_ready  (byte_ready),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .px_we       (px_we),
    .px_addr     (px_addr),
    .px_data     (px_data),
    .panel_ready (panel_ready),
`ifdef LCD_RST_GLITCH_CNT_EN
    .glitch_cnt  (glitch_cnt),
`endif
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       rdy;
    logic       cwe;
    logic [2:0] caddr;
    logic [7:0] cdata;
    logic       prdy;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic rd, logic we,
                              logic [2:0] a, logic [7:0] cd, logic pr);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.rdy = rd;
    x.cwe = we; x.caddr = a; x.cdata = cd; x.prdy = pr;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample just after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    lcd_rst = r;
    byte_valid = v;
    byte_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 0);
    chk({tag, "_cfg_we"}, 32'(cfg_we), 0);
    chk({tag, "_cfg_addr"}, 32'(cfg_addr), 0);
    chk({tag, "_cfg_data"}, 32'(cfg_data), 0);
    chk({tag, "_px_we"}, 32'(px_we), 0);
    chk({tag, "_px_addr"}, 32'(px_addr), 0);
    chk({tag, "_px_data"}, 32'(px_data), 0);
    chk({tag, "_panel_ready"}, 32'(panel_ready), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // Holds lcd_rst low for nlow vectors, releases, and checks CONFIG entry four edges later.
  task automatic panel_reset(input string tag, input int nlow, input logic expect_cfg);
    for (int i = 0; i < nlow; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk({tag, "_low_ready"}, 32'(byte_ready), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk({tag, "_rel_ready"}, 32'(byte_ready), 0);
    end
    step(1'b1, 1'b0, 8'h00);
    chk({tag, "_cfg_ready"}, 32'(byte_ready), 32'(expect_cfg));
    chk({tag, "_panel_ready"}, 32'(panel_ready), 0);
  endtask

  initial begin
    int fd_cnt;
    logic [9:0] ea;
    logic [7:0] ed;

    for (int i = 0; i < 4; i++) tbl[i] = mk(0, 0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    for (int i = 4; i < 8; i++) tbl[i] = mk(1, 0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    tbl[8] = mk(1, 0, 8'h00, 1, 0, 3'd0, 8'h00, 0);
    for (int k = 0; k < 8; k++)
      tbl[9+k] = mk(1, 1, 8'(8'h10 + k), 1, 1, 3'(k), 8'(8'h10 + k), (k == 7) ? 1'b1 : 1'b0);
    tbl[17] = mk(1, 0, 8'h00, 1, 0, 3'd0, 8'h00, 1);

    // Block reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // No bytes accepted before a panel reset sequence
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'hC3);
      chk("noseq_ready", 32'(byte_ready), 0);
      chk("noseq_cfg_we", 32'(cfg_we), 0);
    end

    // Short pulse is rejected as a glitch
    panel_reset("glitch", 2, 1'b0);
`ifdef LCD_RST_GLITCH_CNT_EN
    chk("glitch_cnt", 32'(glitch_cnt), 1);
`endif

    // Valid reset then config bytes from the vector table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].din);
      chk($sformatf("tbl%0d_ready", i), 32'(byte_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_cfg_we", i), 32'(cfg_we), 32'(tbl[i].cwe));
      chk($sformatf("tbl%0d_px_we", i), 32'(px_we), 0);
      chk($sformatf("tbl%0d_panel", i), 32'(panel_ready), 32'(tbl[i].prdy));
      if (tbl[i].cwe) begin
        chk($sformatf("tbl%0d_cfg_addr", i), 32'(cfg_addr), 32'(tbl[i].caddr));
        chk($sformatf("tbl%0d_cfg_data", i), 32'(cfg_data), 32'(tbl[i].cdata));
      end
    end

    // Stream one full frame plus a wrap, continuing up to address 35
    fd_cnt = 0;
    for (int k = 0; k < 1060; k++) begin
      ea = 10'(k % 1024);
      ed = 8'(k + 3);
      step(1'b1, 1'b1, ed);
      chk("px_we", 32'(px_we), 1);
      chk("px_addr", 32'(px_addr), 32'(ea));
      chk("px_data", 32'(px_data), 32'(ed));
      chk("frame_done", 32'(frame_done), (k == 1023) ? 1 : 0);
      chk("px_cfg_we", 32'(cfg_we), 0);
      if (frame_done) fd_cnt++;
    end
    chk("frame_done_count", 32'(fd_cnt), 1);
    chk("stream_panel", 32'(panel_ready), 1);

    // Drop lcd_rst mid-stream: in-flight bytes at 36 and 37 still land
    step(1'b0, 1'b1, 8'h66);
    chk("drop_px_addr36", 32'(px_addr), 36);
    chk("drop_we36", 32'(px_we), 1);
    step(1'b0, 1'b1, 8'h77);
    chk("drop_px_addr37", 32'(px_addr), 37);
    chk("drop_we37", 32'(px_we), 1);
    chk("drop_ready", 32'(byte_ready), 0);
    step(1'b0, 1'b1, 8'h88);
    chk("drop_we_after", 32'(px_we), 0);
    chk("drop_panel", 32'(panel_ready), 0);
    chk("drop_ready2", 32'(byte_ready), 0);
    panel_reset("restart", 1, 1'b1);

    step(1'b1, 1'b1, 8'hA5);
    chk("restart_cfg_we", 32'(cfg_we), 1);
    chk("restart_cfg_addr", 32'(cfg_addr), 0);
    chk("restart_cfg_data", 32'(cfg_data), 32'h A5);
    step(1'b1, 1'b1, 8'h5A);
    chk("restart_cfg_addr1", 32'(cfg_addr), 1);
`ifdef LCD_RST_GLITCH_CNT_EN
    chk("glitch_cnt_kept", 32'(glitch_cnt), 1);
`endif

    // Block reset mid-config clears outputs immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midcfg");
`ifdef LCD_RST_GLITCH_CNT_EN
    chk("glitch_cnt_cleared", 32'(glitch_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h55);
      chk("post_rst_ready", 32'(byte_ready), 0);
      chk("post_rst_cfg_we", 32'(cfg_we), 0);
      chk("post_rst_panel", 32'(panel_ready), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
